// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: Gray decode and write-ingress skid states.
// Both the write side and the read side import this package.
package async_fifo_pkg;

   // Widest pointer the Gray decoder handles. Narrower pointers are zero-extended.
   localparam int PTR_MAX = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_st_e;

   // Zero-extending a Gray code leaves the low binary bits unchanged.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] b;
      b[PTR_MAX-1] = g[PTR_MAX-1];
      for (int i = PTR_MAX-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/wfifo_skid2.sv
// Two-entry skid buffer in front of the FIFO write port.
// The out stage presents to the write port, and the skid stage catches the beat taken while out stalls.
module wfifo_skid2
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             wclr,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DSIZE-1:0] s_data,
   input  logic             wfull,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic             drain
);

   skid_st_e         state_q, state_d;
   logic             rdy_q, rdy_d;
   logic [DSIZE-1:0] out_q, out_d;
   logic [DSIZE-1:0] skid_q, skid_d;
   logic             accept;

   assign s_ready   = rdy_q & ~wclr;
   assign accept    = s_valid & s_ready;
   assign out_valid = (state_q != ST_EMPTY);
   assign drain     = out_valid & ~wfull & ~wclr;
   assign out_data  = out_q;

   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (wclr) begin
         state_d = ST_EMPTY;
         rdy_d   = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               state_d = ST_ONE;
               out_d   = s_data;
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  state_d = ST_TWO;
                  skid_d  = s_data;
                  rdy_d   = 1'b0;
               end else if (accept && drain) begin
                  out_d   = s_data;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: if (drain) begin
               state_d = ST_ONE;
               out_d   = skid_q;
               rdy_d   = 1'b1;
            end
            default: begin
               state_d = ST_EMPTY;
               rdy_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b1;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/wfifo_stream_in.sv
// Write-side ingress of the async FIFO: stream skid buffer driving winc/wdata,
// plus a registered, pessimistic write-side fill level and threshold flag.
module wfifo_stream_in
   import async_fifo_pkg::*;
#(
   parameter int ASIZE  = 4,
   parameter int DSIZE  = 8,
   parameter int THRESH = 12
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             wclr,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DSIZE-1:0] s_data,
   output logic             winc,
   output logic [DSIZE-1:0] wdata,
   input  logic             wfull,
   input  logic [ASIZE:0]   wptr,
   input  logic [ASIZE:0]   wq2_rptr,
   output logic [ASIZE:0]   wlevel,
   output logic             wthresh
);

   localparam int PW = ASIZE + 1;

   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic             drain;
   logic [PW-1:0]    wb, rb, lvl;
   logic [PW-1:0]    wlevel_q, wlevel_d;
   logic             wthresh_q, wthresh_d;

   wfifo_skid2 #(.DSIZE(DSIZE)) u_skid (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .wclr      (wclr),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .wfull     (wfull),
      .out_valid (out_valid),
      .out_data  (out_data),
      .drain     (drain)
   );

   assign winc  = drain;
   assign wdata = out_data;

   // Modular subtraction at pointer width handles the wrap of either pointer.
   assign wb  = PW'(gray2bin(PTR_MAX'(wptr)));
   assign rb  = PW'(gray2bin(PTR_MAX'(wq2_rptr)));
   assign lvl = wb - rb;

   always_comb begin
      wlevel_d  = lvl;
      wthresh_d = (32'(lvl) >= 32'(THRESH));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wlevel_q  <= '0;
         wthresh_q <= 1'b0;
      end else begin
         wlevel_q  <= wlevel_d;
         wthresh_q <= wthresh_d;
      end
   end

   assign wlevel  = wlevel_q;
   assign wthresh = wthresh_q;

endmodule

// File: tb/tb_wfifo_stream_in.sv
// Directed bench for wfifo_stream_in with a behavioural write-pointer/full model
// and a stream driver, logging every write seen on winc/wdata.
module tb_wfifo_stream_in;

   logic       wclk = 1'b0;
   logic       wrst_n, wclr, s_valid, s_ready, winc, wfull, wthresh;
   logic [7:0] s_data, wdata;
   logic [4:0] wptr, wq2_rptr, wlevel;

   // write-pointer / full model, plus override knobs
   logic [4:0] wbin, rbin, wbin_nx, wptr_ovr, rptr_ovr;
   logic       wfull_q, ovr_en, full_ovr;

   int         n_chk = 0, n_fail = 0;
   int         tx_idx = 0, tx_target = 0, viol = 0;
   logic       drv_en = 1'b0;
   logic [7:0] wr_log[$];

   wfifo_stream_in #(.ASIZE(4), .DSIZE(8), .THRESH(12)) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .wclr     (wclr),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .winc     (winc),
      .wdata    (wdata),
      .wfull    (wfull),
      .wptr     (wptr),
      .wq2_rptr (wq2_rptr),
      .wlevel   (wlevel),
      .wthresh  (wthresh)
   );

   always #5 wclk = ~wclk;

   assign wbin_nx  = wbin + {4'd0, winc};
   assign wptr     = ovr_en ? wptr_ovr : (wbin ^ (wbin >> 1));
   assign wq2_rptr = ovr_en ? rptr_ovr : (rbin ^ (rbin >> 1));
   assign wfull    = full_ovr | wfull_q;

   always @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin    <= 5'd0;
         wfull_q <= 1'b0;
      end else begin
         wbin    <= wbin_nx;
         wfull_q <= ((wbin_nx - rbin) == 5'd16);
      end
   end

   // Beat is presented for a whole cycle; if s_ready is high mid-cycle it is taken at the next edge.
   initial forever begin
      @(negedge wclk); #1;
      if (drv_en) begin
         if (tx_idx < tx_target) begin
            s_valid = 1'b1;
            s_data  = 8'(tx_idx);
            if (s_ready) tx_idx++;
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   always @(negedge wclk) begin
      #2;
      if (wrst_n) begin
         if (winc) wr_log.push_back(wdata);
         if (winc && wfull) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] logged(input int i);
      return (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hDEAD;
   endfunction

   initial begin
      wrst_n = 1'b0; wclr = 1'b0; s_valid = 1'b0; s_data = 8'd0;
      rbin = 5'd0; ovr_en = 1'b0; full_ovr = 1'b0;
      wptr_ovr = 5'd0; rptr_ovr = 5'd0;
      repeat (3) @(negedge wclk);
      wrst_n = 1'b1;

      // 20 back-to-back beats, reads stalled
      drv_en = 1'b1; tx_target = 20;
      repeat (40) @(negedge wclk);
      #1;
      chk("t2_nwrites", 32'(wr_log.size()), 32'd16);
      for (int i = 0; i < 16; i++) chk($sformatf("t2_wr%0d", i), logged(i), 32'(i));
      chk("t2_accepted", 32'(tx_idx), 32'd18);
      chk("t2_s_ready", 32'(s_ready), 32'd0);
      chk("t2_winc", 32'(winc), 32'd0);
      chk("t2_wdata_held", 32'(wdata), 32'h10);
      chk("t2_viol", 32'(viol), 32'd0);
      chk("t2_wlevel", 32'(wlevel), 32'd16);
      chk("t2_wthresh", 32'(wthresh), 32'd1);

      // free four slots
      @(negedge wclk); rbin = 5'd4;
      repeat (20) @(negedge wclk);
      #1;
      chk("t3_nwrites", 32'(wr_log.size()), 32'd20);
      for (int i = 16; i < 20; i++) chk($sformatf("t3_wr%0d", i), logged(i), 32'(i));
      chk("t3_accepted", 32'(tx_idx), 32'd20);
      chk("t3_s_ready", 32'(s_ready), 32'd1);
      chk("t3_viol", 32'(viol), 32'd0);
      chk("t3_wlevel", 32'(wlevel), 32'd16);

      // fill skid again, then reset mid-stream
      tx_target = 22;
      repeat (8) @(negedge wclk);
      #1;
      chk("t1_pre_s_ready", 32'(s_ready), 32'd0);
      @(negedge wclk);
      wrst_n = 1'b0;
      #1;
      chk("t1_s_ready", 32'(s_ready), 32'd1);
      chk("t1_winc", 32'(winc), 32'd0);
      chk("t1_wlevel", 32'(wlevel), 32'd0);
      chk("t1_wthresh", 32'(wthresh), 32'd0);
      chk("t1_wdata", 32'(wdata), 32'd0);
      drv_en = 1'b0; s_valid = 1'b0; rbin = 5'd0;
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
      wr_log.delete();

      // level arithmetic
      @(negedge wclk); ovr_en = 1'b1; wptr_ovr = 5'b01111; rptr_ovr = 5'b00010;
      @(negedge wclk); #1;
      chk("t4_wlevel", 32'(wlevel), 32'd7);
      chk("t4_wthresh", 32'(wthresh), 32'd0);
      @(negedge wclk); wptr_ovr = 5'b00011; rptr_ovr = 5'b10001;
      @(negedge wclk); #1;
      chk("t4_wrap_wlevel", 32'(wlevel), 32'd4);
      @(negedge wclk); wptr_ovr = 5'b11000; rptr_ovr = 5'b00110;
      @(negedge wclk); #1;
      chk("t5_wlevel12", 32'(wlevel), 32'd12);
      chk("t5_wthresh1", 32'(wthresh), 32'd1);
      @(negedge wclk); rptr_ovr = 5'b00111;
      #1;
      chk("t5_latency", 32'(wlevel), 32'd12);
      @(negedge wclk); #1;
      chk("t5_wlevel11", 32'(wlevel), 32'd11);
      chk("t5_wthresh0", 32'(wthresh), 32'd0);
      ovr_en = 1'b0;

      // wclr while TWO with s_valid held
      full_ovr = 1'b1;
      @(negedge wclk); s_valid = 1'b1; s_data = 8'hA1;
      @(negedge wclk); s_data = 8'hA2;
      @(negedge wclk); s_data = 8'hA3;
      #1;
      chk("t6_two_s_ready", 32'(s_ready), 32'd0);
      chk("t6_two_wdata", 32'(wdata), 32'hA1);
      @(negedge wclk); wclr = 1'b1; full_ovr = 1'b0;
      #1;
      chk("t6_clr_s_ready", 32'(s_ready), 32'd0);
      chk("t6_clr_winc", 32'(winc), 32'd0);
      @(negedge wclk); wclr = 1'b0; s_valid = 1'b0;
      #1;
      chk("t6_post_winc", 32'(winc), 32'd0);
      chk("t6_post_s_ready", 32'(s_ready), 32'd1);
      @(negedge wclk); s_valid = 1'b1; s_data = 8'hB0;
      @(negedge wclk); s_valid = 1'b0;
      #1;
      chk("t6_new_winc", 32'(winc), 32'd1);
      chk("t6_new_wdata", 32'(wdata), 32'hB0);
      @(negedge wclk); #3;
      chk("t6_nwrites", 32'(wr_log.size()), 32'd1);
      chk("t6_first_write", logged(0), 32'hB0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
